mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. It turns MemRead/MemWrite plus the ALU address and store data into a request/acknowledge transaction toward a variable-latency data memory. It holds the pipeline through the stall output until the access completes or times out, and presents load data to the MEM/WB register.

Parameters:
TIMEOUT, 16, max cycles the request may be outstanding without ack before abort; 0 = no timeout
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
MemRead_i  input  1  load in MEM stage (from EX/MEM)
MemWrite_i  input  1  store in MEM stage (from EX/MEM)
ALU_data_i  input  ADDR_W  access address
writeData_i  input  DATA_W  store data
stall_o  output  1  hold pipeline registers (drives EX/MEM stall_i and upstream)
data_o  output  DATA_W  load data to MEM/WB
err_o  output  1  one-cycle pulse: access aborted by timeout
mem_req_o  output  1  memory request
mem_we_o  output  1  1 = write, 0 = read
mem_addr_o  output  ADDR_W  request address
mem_wdata_o  output  DATA_W  request write data
mem_ack_i  input  1  memory completion, single-cycle pulse
mem_rdata_i  input  DATA_W  read data, valid when mem_ack_i=1

Behaviour:
- access = MemRead_i | MemWrite_i. Both set counts as a write (MemWrite_i priority).
- mem_addr_o, mem_wdata_o and mem_we_o pass combinationally from ALU_data_i, writeData_i and MemWrite_i. Stability during an access comes from stall_o holding EX/MEM.
- FSM states: IDLE, WAIT. Cycle counter cnt, width clog2(TIMEOUT+1).
- IDLE:
  - mem_req_o = access.
  - access & mem_ack_i: zero-wait completion; stall_o=0; stay IDLE.
  - access & !mem_ack_i: stall_o=1; go to WAIT; cnt<=1.
  - !access: stall_o=0; mem_ack_i ignored.
- WAIT:
  - mem_ack_i: mem_req_o=1, stall_o=0, go to IDLE.
  - !mem_ack_i & TIMEOUT!=0 & cnt==TIMEOUT: mem_req_o=0, stall_o=0, err_o=1, go to IDLE. Request was high for exactly TIMEOUT cycles.
  - Otherwise: mem_req_o=1, stall_o=1, cnt<=cnt+1.
- stall_o is combinational, so EX/MEM advances on the same edge the ack or abort is seen.
- Load data:
  - data_o = mem_rdata_i in an ack cycle of a read; otherwise the registered rdata_q.
  - rdata_q <= mem_rdata_i on ack of a read.
  - A timeout on a read loads rdata_q <= 0 and drives data_o=0 in the abort cycle.
  - Writes never change rdata_q.
- Back-to-back accesses: after completion the FSM is in IDLE. The next instruction's access issues a new request the following cycle. The same access is never re-issued.
- Reset (any time, including mid-WAIT): state=IDLE, cnt=0, rdata_q=0, err_o=0.
  - mem_req_o/stall_o then follow the IDLE equations, so both are 0 while MemRead_i=MemWrite_i=0.
  - A transaction abandoned by reset is not completed. A late ack is treated per IDLE rules.
- The memory must not ack after mem_req_o drops. Behaviour on a spurious ack: ignored if !access; completes the current access if access.

Optional Feature:
MEM_STALL_CNT_EN:
- Defined: adds output stall_cycles_o [31:0], the count of cycles with stall_o=1.
  - Reset to 0; wraps from 0xFFFFFFFF to 0.
  - Increments on the clock edge ending each stalled cycle.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Zero-wait load: MemRead_i=1, addr 0x40, mem_ack_i=1 same cycle with rdata 0xDEADBEEF -> stall_o=0 throughout, data_o=0xDEADBEEF that cycle and after.
- 3-cycle store: MemWrite_i=1, addr 0x80, wdata 0x12345678, ack on 3rd req cycle -> mem_req_o high 3 cycles, mem_we_o=1, stall_o=1 for 2 cycles, data_o unchanged.
- Timeout (TIMEOUT=4): read, no ack -> mem_req_o high 4 cycles, 5th cycle err_o=1, stall_o=0, data_o=0, then IDLE.
- Back-to-back: load (ack after 2 cycles) followed by store at 0x84 -> second mem_req_o asserts the cycle after first ack, with no duplicate request for the load.
- Reset mid-WAIT: assert rst_i low on 2nd wait cycle with MemRead_i=0 -> mem_req_o=0, stall_o=0, err_o=0 immediately; late ack ignored.
- MEM_STALL_CNT_EN: 3-cycle store + 4-timeout read from reset -> stall_cycles_o=6.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage request/acknowledge controller toward a variable-latency data memory.
// Optional `MEM_STALL_CNT_EN` adds a free-running stalled-cycle counter output.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] ALU_data_i,
    input  logic [DATA_W-1:0] writeData_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles_o
`endif
);

    localparam int unsigned    CntW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
    localparam bit             HasTimeout = (TIMEOUT != 0);

    typedef enum logic {StIdle, StWait} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [DATA_W-1:0] rdata_q;

    logic access, is_read, done, abort;

    assign access      = MemRead_i | MemWrite_i;
    assign is_read     = MemRead_i & ~MemWrite_i;
    assign mem_we_o    = MemWrite_i;
    assign mem_addr_o  = ALU_data_i;
    assign mem_wdata_o = writeData_i;

    // Handshake decode; stall_o stays combinational so EX/MEM moves on the completing edge.
    always_comb begin
        mem_req_o = 1'b0;
        stall_o   = 1'b0;
        err_o     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            StIdle: begin
                mem_req_o = access;
                stall_o   = access & ~mem_ack_i;
                done      = access & mem_ack_i;
            end
            StWait: begin
                if (mem_ack_i) begin
                    mem_req_o = 1'b1;
                    done      = 1'b1;
                end else if (HasTimeout && (cnt_q == TimeoutCnt)) begin
                    abort = 1'b1;
                    err_o = 1'b1;
                end else begin
                    mem_req_o = 1'b1;
                    stall_o   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        data_o = rdata_q;
        if (done && is_read) begin
            data_o = mem_rdata_i;
        end else if (abort && is_read) begin
            data_o = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == StIdle) begin
                if (access && !mem_ack_i) begin
                    state_q <= StWait;
                    cnt_q   <= CntW'(1);
                end
            end else if (done || abort) begin
                state_q <= StIdle;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (done && is_read) begin
                rdata_q <= mem_rdata_i;
            end else if (abort && is_read) begin
                rdata_q <= '0;
            end
        end
    end

`ifdef MEM_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cycles_o <= '0;
        end else if (stall_o) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with TIMEOUT=4.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] ALU_data_i, writeData_i;
    logic        stall_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] data_o, mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cycles_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(
        .TIMEOUT(4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .ALU_data_i (ALU_data_i),
        .writeData_i(writeData_i),
        .stall_o    (stall_o),
        .data_o     (data_o),
        .err_o      (err_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
`ifdef MEM_STALL_CNT_EN
        ,
        .stall_cycles_o(stall_cycles_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then let combinational outputs settle.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic ack, input logic [31:0] rdat);
        @(posedge clk_i);
        #1;
        MemRead_i   = rd;
        MemWrite_i  = wr;
        ALU_data_i  = addr;
        writeData_i = wd;
        mem_ack_i   = ack;
        mem_rdata_i = rdat;
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic req, input logic stall,
                           input logic err, input logic [31:0] dat);
        chk({tag, ".req"},   32'(mem_req_o), 32'(req));
        chk({tag, ".stall"}, 32'(stall_o),   32'(stall));
        chk({tag, ".err"},   32'(err_o),     32'(err));
        chk({tag, ".data"},  data_o,         dat);
    endtask

    initial begin
        rst_i = 1'b0;
        MemRead_i = 1'b0; MemWrite_i = 1'b0; ALU_data_i = '0; writeData_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        #3;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Zero-wait load
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF);
        chk_ctl("zw_load", 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        chk("zw_load.we", 32'(mem_we_o), 32'h0);
        chk("zw_load.addr", mem_addr_o, 32'h40);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk_ctl("zw_load.after", 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);

        // 3-cycle store, ack on the third request cycle
        drive(1'b0, 1'b1, 32'h80, 32'h12345678, 1'b0, 32'h0);
        chk_ctl("st.c1", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        chk("st.we", 32'(mem_we_o), 32'h1);
        chk("st.addr", mem_addr_o, 32'h80);
        chk("st.wdata", mem_wdata_o, 32'h12345678);
        drive(1'b0, 1'b1, 32'h80, 32'h12345678, 1'b0, 32'h0);
        chk_ctl("st.c2", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        drive(1'b0, 1'b1, 32'h80, 32'h12345678, 1'b1, 32'hFFFF0000);
        chk_ctl("st.c3", 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk_ctl("st.after", 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);

        // Read timeout: 4 request cycles, abort on the 5th
        drive(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0);
        chk_ctl("to.c1", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0);
        chk_ctl("to.c2", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0);
        chk_ctl("to.c3", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0);
        chk_ctl("to.c4", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        drive(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0);
        chk_ctl("to.abort", 1'b0, 1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk_ctl("to.after", 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef MEM_STALL_CNT_EN
        chk("stall_cycles", stall_cycles_o, 32'd6);
`endif

        // Back-to-back: load acked after 2 cycles, then store at 0x84
        drive(1'b1, 1'b0, 32'h48, 32'h0, 1'b0, 32'h0);
        chk_ctl("b2b.ld1", 1'b1, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 32'hCAFEF00D);
        chk_ctl("b2b.ld2", 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
        drive(1'b0, 1'b1, 32'h84, 32'hA5A5A5A5, 1'b0, 32'h0);
        chk_ctl("b2b.st1", 1'b1, 1'b1, 1'b0, 32'hCAFEF00D);
        chk("b2b.st.we", 32'(mem_we_o), 32'h1);
        chk("b2b.st.addr", mem_addr_o, 32'h84);
        drive(1'b0, 1'b1, 32'h84, 32'hA5A5A5A5, 1'b1, 32'h0);
        chk_ctl("b2b.st2", 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk_ctl("b2b.after", 1'b0, 1'b0, 1'b0, 32'hCAFEF00D);

        // Reset during WAIT, then a late ack with no access
        drive(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0);
        chk_ctl("rst.c1", 1'b1, 1'b1, 1'b0, 32'hCAFEF00D);
        drive(1'b0, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0);
        rst_i = 1'b0;
        #1;
        chk_ctl("rst.mid", 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55555555);
        rst_i = 1'b1;
        #1;
        chk_ctl("rst.late_ack", 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk_ctl("rst.after", 1'b0, 1'b0, 1'b0, 32'h0);

        // A fresh load still works after the reset
        drive(1'b1, 1'b0, 32'h60, 32'h0, 1'b1, 32'h0BADF00D);
        chk_ctl("post_rst.ld", 1'b1, 1'b0, 1'b0, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
